// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the uart transmit-side blocks.
//
// Contents:
//   arb_state_t : arbiter state encoding (IDLE, HDR, XFER)
//   UART_W      : uart word width; every byte stream feeding the uart uses it
//   HDR_PREFIX  : upper-nibble pattern of the optional requester-ID header
//                 byte for the default 8-bit word and 4-bit ID field.
//                 The low bits carry the requester index.
// ---------------------------------------------------------------------------
package uart_pkg;

  // ST_HDR is only reachable when the arbiter is built with UART_ARB_ID_HDR_EN.
  // The encoding keeps it anyway, so both builds share one state type.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_XFER = 2'd2
  } arb_state_t;

  localparam int UART_W = 8;

  localparam logic [UART_W-1:0] HDR_PREFIX = 8'hF0;

endpackage : uart_pkg

// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundles the requester-side and FIFO-side signals of the uart tx arbiter.
//
// Signals:
//   req       [N]    per-requester valid
//   data      [N*W]  packed bytes, requester i uses data[i*W +: W]
//   last      [N]    presented byte ends the packet
//   ack       [N]    one-hot, byte of requester i accepted this cycle
//   fifo_full        uart tx FIFO full
//   fifo_wr          write strobe to uart wr
//   fifo_data [W]    byte to uart in_data
//   grant     [N]    registered one-hot current owner, 0 when idle
//   busy             arbiter not idle
//
// Modports:
//   slave  : the arbiter's view
//   master : the view of whoever drives the requesters and the FIFO status
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);

  logic [N-1:0]   req;
  logic [N*W-1:0] data;
  logic [N-1:0]   last;
  logic [N-1:0]   ack;
  logic           fifo_full;
  logic           fifo_wr;
  logic [W-1:0]   fifo_data;
  logic [N-1:0]   grant;
  logic           busy;

  modport slave (
    input  req, data, last, fifo_full,
    output ack, fifo_wr, fifo_data, grant, busy
  );

  modport master (
    output req, data, last, fifo_full,
    input  ack, fifo_wr, fifo_data, grant, busy
  );

endinterface : uart_tx_arbiter_if

// File: rtl/uart_rr_pick.sv
// ---------------------------------------------------------------------------
// uart_rr_pick
// Combinational round-robin priority picker. Scans the request vector
// starting one position after the pointer and wrapping modulo N, and
// returns the first asserted request. Written standalone so the RX demux
// can reuse it.
//
// Parameters:
//   N   : number of requesters (2..16)
//
// Ports:
//   i_req [N]   request vector
//   i_ptr [IW]  index of the most recently served requester; it gets
//               the lowest priority in this pick
//   o_gnt [N]   one-hot selection, 0 when no request is asserted
//   o_idx [IW]  binary index of the selection, 0 when none
// ---------------------------------------------------------------------------
module uart_rr_pick #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);

  logic          w_found;
  logic [IW:0]   w_sum;
  logic [IW-1:0] w_pos;

  // Walk offsets 1..N from the pointer. The sum is one bit wider than an
  // index and brought back into range by a single subtraction, which keeps
  // the wrap correct for non-power-of-two N without a divider.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_pos   = '0;
    for (int k = 1; k <= N; k++) begin
      w_sum = {1'b0, i_ptr} + (IW+1)'(k);
      if (w_sum >= (IW+1)'(N)) begin
        w_sum = w_sum - (IW+1)'(N);
      end
      w_pos = w_sum[IW-1:0];
      if (!w_found && i_req[w_pos]) begin
        w_found      = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = w_pos;
      end
    end
  end

endmodule : uart_rr_pick

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Round-robin, packet-locked arbiter that shares the single write port of
// the uart transmit FIFO between N byte-stream requesters. A granted
// requester keeps the port until its last byte is accepted, so packets
// never interleave on the serial line.
//
// Parameters:
//   N   : number of requesters (2..16)
//   W   : byte width, must equal the uart word width
//   IDW : requester-ID field width in the optional header, N <= 2**IDW
//
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : uart_tx_arbiter_if.slave (req/data/last/ack, fifo_full/fifo_wr/
//         fifo_data, grant, busy)
//
// Build option:
//   UART_ARB_ID_HDR_EN : when defined, each packet is preceded by one
//                        header byte {ones, owner id} written from state HDR.
// ---------------------------------------------------------------------------
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N   = 4,
  parameter int W   = UART_W,
  parameter int IDW = 4
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_arbiter_if.slave  bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  // Configuration mistakes are caught at elaboration rather than in silicon.
  if (N < 2 || N > 16) begin : g_badN
    $error("uart_tx_arbiter: N must be in 2..16");
  end
  if (N > (1 << IDW)) begin : g_badIdw
    $error("uart_tx_arbiter: N exceeds the ID field range");
  end
  if (W != UART_W) begin : g_badW
    $error("uart_tx_arbiter: W must equal the uart word width");
  end

  arb_state_t    r_state;
  arb_state_t    w_nextState;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] r_rrPtr;
  logic [N-1:0]  r_grant;

  logic [IW-1:0] w_pickIdx;
  logic [N-1:0]  w_pickGnt;
  logic [W-1:0]  w_slice [N];
  logic          w_ownerReq;
  logic          w_ownerLast;
  logic [W-1:0]  w_ownerData;
  logic          w_fifoWr;
  logic [W-1:0]  w_fifoData;
  logic [N-1:0]  w_ack;
`ifdef UART_ARB_ID_HDR_EN
  logic [W-1:0]  w_hdrByte;
`endif

  uart_rr_pick #(.N(N)) u_pick (
    .i_req (bus.req),
    .i_ptr (r_rrPtr),
    .o_gnt (w_pickGnt),
    .o_idx (w_pickIdx)
  );

  // Unpack the byte lanes so the owner's byte is a plain array lookup.
  for (genvar g = 0; g < N; g++) begin : g_slice
    assign w_slice[g] = bus.data[g*W +: W];
  end

  assign w_ownerReq  = bus.req[r_owner];
  assign w_ownerLast = bus.last[r_owner];
  assign w_ownerData = w_slice[r_owner];

`ifdef UART_ARB_ID_HDR_EN
  // Header: all-ones above the ID field, owner index inside it.
  assign w_hdrByte = {{(W-IDW){1'b1}}, IDW'(r_owner)};
`endif

  // Next state and the same-cycle FIFO strobe. Writes are gated by
  // fifo_full here, so a full FIFO simply stalls the current byte and the
  // requester keeps presenting it.
  always_comb begin
    w_nextState = r_state;
    w_fifoWr    = 1'b0;
    w_fifoData  = '0;
    w_ack       = '0;
    case (r_state)
      ST_IDLE: begin
        if (|bus.req) begin
`ifdef UART_ARB_ID_HDR_EN
          w_nextState = ST_HDR;
`else
          w_nextState = ST_XFER;
`endif
        end
      end
`ifdef UART_ARB_ID_HDR_EN
      ST_HDR: begin
        w_fifoData = w_hdrByte;
        w_fifoWr   = ~bus.fifo_full;
        if (!bus.fifo_full) begin
          w_nextState = ST_XFER;
        end
      end
`endif
      ST_XFER: begin
        w_fifoData = w_ownerData;
        w_fifoWr   = w_ownerReq & ~bus.fifo_full;
        // r_grant is exactly onehot(owner) while in XFER.
        w_ack      = r_grant & {N{w_fifoWr}};
        if (w_fifoWr && w_ownerLast) begin
          w_nextState = ST_IDLE;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State, ownership and round-robin pointer. The pointer moves only when a
  // packet completes, so the requester just served drops to lowest priority
  // and a reset returns top priority to requester 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_owner <= '0;
      r_grant <= '0;
      r_rrPtr <= IW'(N-1);
    end else begin
      r_state <= w_nextState;
      if (r_state == ST_IDLE && |bus.req) begin
        r_owner <= w_pickIdx;
        r_grant <= w_pickGnt;
      end
      if (r_state == ST_XFER && w_fifoWr && w_ownerLast) begin
        r_rrPtr <= r_owner;
        r_grant <= '0;
      end
    end
  end

  assign bus.fifo_wr   = w_fifoWr;
  assign bus.fifo_data = w_fifoData;
  assign bus.ack       = w_ack;
  assign bus.grant     = r_grant;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule : uart_tx_arbiter

// File: tb/tb_uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_arbiter
// Directed, table-driven bench for uart_tx_arbiter with N=4, W=8, IDW=4.
// Inputs change 1 time unit after each rising edge and outputs are compared
// 1 unit later, well clear of the next edge.
// Build option: UART_ARB_ID_HDR_EN selects the header-byte sequence in
// place of the header-less packet sequences.
// ---------------------------------------------------------------------------
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic [N-1:0]   last;
    logic           full;
    logic           expWr;
    logic [W-1:0]   expData;
    logic [N-1:0]   expAck;
    logic [N-1:0]   expGrant;
    logic           expBusy;
  } vec_t;

  logic clk;
  logic rst;
  int   checkCount;
  int   errorCount;

  uart_tx_arbiter_if #(.N(N), .W(W)) bus ();

  uart_tx_arbiter #(.N(N), .W(W), .IDW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guards against a stuck simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(
    input logic [N-1:0] req, input logic [N*W-1:0] data,
    input logic [N-1:0] last, input logic full, input logic expWr,
    input logic [W-1:0] expData, input logic [N-1:0] expAck,
    input logic [N-1:0] expGrant, input logic expBusy);
    vec_t v;
    v.req = req; v.data = data; v.last = last; v.full = full;
    v.expWr = expWr; v.expData = expData; v.expAck = expAck;
    v.expGrant = expGrant; v.expBusy = expBusy;
    return v;
  endfunction

  task automatic applyStimulus(input logic [N-1:0] req,
                               input logic [N*W-1:0] data,
                               input logic [N-1:0] last,
                               input logic full, input logic rstVal);
    bus.req       = req;
    bus.data      = data;
    bus.last      = last;
    bus.fifo_full = full;
    rst           = rstVal;
  endtask

  // fifo_data is only meaningful while fifo_wr is high.
  task automatic checkOutput(input string name, input logic expWr,
                             input logic [W-1:0] expData,
                             input logic [N-1:0] expAck,
                             input logic [N-1:0] expGrant,
                             input logic expBusy);
    checkCount++;
    if (bus.fifo_wr !== expWr) begin
      errorCount++;
      $display("[TB] FAIL %s fifo_wr: got %0b expected %0b", name, bus.fifo_wr, expWr);
    end
    if (expWr) begin
      checkCount++;
      if (bus.fifo_data !== expData) begin
        errorCount++;
        $display("[TB] FAIL %s fifo_data: got %h expected %h", name, bus.fifo_data, expData);
      end
    end
    checkCount++;
    if (bus.ack !== expAck) begin
      errorCount++;
      $display("[TB] FAIL %s ack: got %b expected %b", name, bus.ack, expAck);
    end
    checkCount++;
    if (bus.grant !== expGrant) begin
      errorCount++;
      $display("[TB] FAIL %s grant: got %b expected %b", name, bus.grant, expGrant);
    end
    checkCount++;
    if (bus.busy !== expBusy) begin
      errorCount++;
      $display("[TB] FAIL %s busy: got %0b expected %0b", name, bus.busy, expBusy);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    applyStimulus('0, '0, '0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  vec_t vecs[26];

  initial begin
    checkCount = 0;
    errorCount = 0;
    applyStimulus('0, '0, '0, 1'b0, 1'b1);

    // Single-owner packets, stall, non-interleaving, dropped req.
    vecs[0]  = mkVec(4'h0, 32'h0,        4'h0, 0, 0, 8'h00, 4'h0, 4'h0, 0);
    vecs[1]  = mkVec(4'h1, 32'h00000011, 4'h0, 0, 0, 8'h00, 4'h0, 4'h0, 0);
    vecs[2]  = mkVec(4'h1, 32'h00000011, 4'h0, 0, 1, 8'h11, 4'h1, 4'h1, 1);
    vecs[3]  = mkVec(4'h1, 32'h00000022, 4'h0, 0, 1, 8'h22, 4'h1, 4'h1, 1);
    vecs[4]  = mkVec(4'h1, 32'h00000033, 4'h1, 0, 1, 8'h33, 4'h1, 4'h1, 1);
    vecs[5]  = mkVec(4'h0, 32'h0,        4'h0, 0, 0, 8'h00, 4'h0, 4'h0, 0);
    vecs[6]  = mkVec(4'h8, 32'hA5000000, 4'h8, 0, 0, 8'h00, 4'h0, 4'h0, 0);
    for (int i = 7; i <= 11; i++)
      vecs[i] = mkVec(4'h8, 32'hA5000000, 4'h8, 1, 0, 8'h00, 4'h0, 4'h8, 1);
    vecs[12] = mkVec(4'h8, 32'hA5000000, 4'h8, 0, 1, 8'hA5, 4'h8, 4'h8, 1);
    vecs[13] = mkVec(4'h0, 32'h0,        4'h0, 0, 0, 8'h00, 4'h0, 4'h0, 0);
    vecs[14] = mkVec(4'h2, 32'h0000B100, 4'h0, 0, 0, 8'h00, 4'h0, 4'h0, 0);
    vecs[15] = mkVec(4'h6, 32'h00C1B100, 4'h4, 0, 1, 8'hB1, 4'h2, 4'h2, 1);
    vecs[16] = mkVec(4'h6, 32'h00C1B200, 4'h4, 0, 1, 8'hB2, 4'h2, 4'h2, 1);
    vecs[17] = mkVec(4'h6, 32'h00C1B300, 4'h6, 0, 1, 8'hB3, 4'h2, 4'h2, 1);
    vecs[18] = mkVec(4'h4, 32'h00C10000, 4'h4, 0, 0, 8'h00, 4'h0, 4'h0, 0);
    vecs[19] = mkVec(4'h4, 32'h00C10000, 4'h4, 0, 1, 8'hC1, 4'h4, 4'h4, 1);
    vecs[20] = mkVec(4'h0, 32'h0,        4'h0, 0, 0, 8'h00, 4'h0, 4'h0, 0);
    vecs[21] = mkVec(4'h1, 32'h000000D1, 4'h0, 0, 0, 8'h00, 4'h0, 4'h0, 0);
    vecs[22] = mkVec(4'h0, 32'h000000D1, 4'h0, 0, 0, 8'h00, 4'h0, 4'h1, 1);
    vecs[23] = mkVec(4'h8, 32'h000000D1, 4'h0, 0, 0, 8'h00, 4'h0, 4'h1, 1);
    vecs[24] = mkVec(4'h9, 32'h000000D2, 4'h1, 0, 1, 8'hD2, 4'h1, 4'h1, 1);
    vecs[25] = mkVec(4'h0, 32'h0,        4'h0, 0, 0, 8'h00, 4'h0, 4'h0, 0);

    doReset();

`ifndef UART_ARB_ID_HDR_EN
    $display("[TB] table vectors");
    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i].req, vecs[i].data, vecs[i].last, vecs[i].full, 1'b0);
      #1;
      checkOutput($sformatf("row%0d", i), vecs[i].expWr, vecs[i].expData,
                  vecs[i].expAck, vecs[i].expGrant, vecs[i].expBusy);
      nextCycle();
    end

    // All four requesting 1-byte packets: 2 cycles each, grants rotate 0..3.
    $display("[TB] round robin");
    doReset();
    for (int p = 0; p < 8; p++) begin
      applyStimulus(4'hF, 32'h43424140, 4'hF, 1'b0, 1'b0);
      #1;
      checkOutput($sformatf("rr%0d_idle", p), 1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
      nextCycle();
      #1;
      checkOutput($sformatf("rr%0d_xfer", p), 1'b1, 8'(8'h40 + (p % 4)),
                  4'(1 << (p % 4)), 4'(1 << (p % 4)), 1'b1);
      nextCycle();
    end

    // Reset after two bytes of a 4-byte packet from requester 0.
    $display("[TB] reset mid-packet");
    applyStimulus(4'h1, 32'h000000E1, 4'h0, 1'b0, 1'b0);
    #1;
    checkOutput("rst_arb", 1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
    nextCycle();
    #1;
    checkOutput("rst_b1", 1'b1, 8'hE1, 4'h1, 4'h1, 1'b1);
    nextCycle();
    applyStimulus(4'h1, 32'h000000E2, 4'h0, 1'b0, 1'b0);
    #1;
    checkOutput("rst_b2", 1'b1, 8'hE2, 4'h1, 4'h1, 1'b1);
    nextCycle();
    applyStimulus(4'h0, 32'h000000E3, 4'h0, 1'b0, 1'b1);
    #1;
    checkOutput("rst_pulse", 1'b0, 8'h00, 4'h0, 4'h1, 1'b1);
    nextCycle();
    applyStimulus(4'hA, 32'hF300F100, 4'hA, 1'b0, 1'b0);
    #1;
    checkOutput("rst_after", 1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
    nextCycle();
    #1;
    checkOutput("rst_regrant", 1'b1, 8'hF1, 4'h2, 4'h2, 1'b1);
    nextCycle();
`else
    // Requester 2 sends 8'h7E; header F2 first (one full-FIFO stall), no ack on it.
    $display("[TB] header sequence");
    applyStimulus(4'h4, 32'h007E0000, 4'h4, 1'b0, 1'b0);
    #1;
    checkOutput("hdr_arb", 1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
    nextCycle();
    applyStimulus(4'h4, 32'h007E0000, 4'h4, 1'b1, 1'b0);
    #1;
    checkOutput("hdr_stall", 1'b0, 8'h00, 4'h0, 4'h4, 1'b1);
    nextCycle();
    applyStimulus(4'h4, 32'h007E0000, 4'h4, 1'b0, 1'b0);
    #1;
    checkOutput("hdr_byte", 1'b1, HDR_PREFIX | 8'h02, 4'h0, 4'h4, 1'b1);
    nextCycle();
    #1;
    checkOutput("hdr_payload", 1'b1, 8'h7E, 4'h4, 4'h4, 1'b1);
    nextCycle();
    applyStimulus(4'h0, 32'h0, 4'h0, 1'b0, 1'b0);
    #1;
    checkOutput("hdr_done", 1'b0, 8'h00, 4'h0, 4'h0, 1'b0);
    nextCycle();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule : tb_uart_tx_arbiter

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin, packet-locked arbiter that shares the single transmit-FIFO write port of the uart block between N byte-stream requesters.
- Sits between the requesters and uart's wr/in_data/full pins.
- Once a requester is granted, it keeps the port until its last byte is accepted, so packets are never interleaved on the serial line.

Parameters:
- N, 4, number of requesters (2..16)
- W, 8, byte width; must equal the uart word width
- IDW, 4, requester-ID field width in the optional header byte; requires N <= 2**IDW

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req  in  N  per-requester valid; a byte is presented on its data slice
- data  in  N*W  packed bytes; requester i uses data[i*W +: W]
- last  in  N  per-requester flag: the presented byte ends the packet
- ack  out  N  one-hot; byte of requester i accepted this cycle
- fifo_full  in  1  uart tx FIFO full
- fifo_wr  out  1  write strobe to uart wr
- fifo_data  out  W  byte to uart in_data
- grant  out  N  one-hot registered current owner; 0 when idle
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - state=IDLE, grant=0, owner=0, rr_ptr=N-1 (requester 0 has top priority after reset).
  - Combinational outputs follow immediately: fifo_wr=0, ack=0, busy=0.
  - Reset mid-packet abandons the packet; no further bytes are written.
- States: IDLE, HDR (only when the optional feature is compiled in), XFER.
- IDLE:
  - If req != 0, select the first asserted requester scanning rr_ptr+1, rr_ptr+2, ... modulo N.
  - Register owner and grant=onehot(owner); next state is XFER (HDR when the feature is enabled).
  - There is no transfer in the arbitration cycle, so minimum packet overhead is 1 cycle.
- XFER:
  - fifo_wr = req[owner] & ~fifo_full (combinational, same cycle).
  - fifo_data = data slice of owner; ack = onehot(owner) & {N{fifo_wr}}.
  - On fifo_wr & last[owner]: rr_ptr<=owner, grant<=0, next state IDLE.
  - Otherwise stay in XFER.
- fifo_full:
  - Stalls with no write and no ack; the requester holds its byte.
  - The arbiter never writes while full, so bytes are never lost.
- Requester drops req mid-packet: grant is held in XFER indefinitely, with no writes.
- Other requests during a packet are ignored until the packet completes.
- Single-byte packet (last=1 on the first byte): XFER lasts exactly 1 cycle when the FIFO is not full.
- Back-to-back: a requester whose packet just ended has lowest priority in the next arbitration.
- fifo_data is don't-care when fifo_wr=0; drive it as the owner slice, or 0 in IDLE.

Optional Feature:
- Macro: UART_ARB_ID_HDR_EN.
- Defined:
  - After arbitration, state HDR writes one header byte before the payload.
  - Header byte = {{(W-IDW){1'b1}}, owner[IDW-1:0]} (W=8, IDW=4 gives 8'hF0|owner).
  - The header is written when ~fifo_full, with ack=0; then state goes to XFER.
  - A full FIFO stalls in HDR.
- Undefined: the HDR state and its logic are absent; IDLE goes directly to XFER.

Decomposition:
- Shared package uart_pkg:
  - state encoding typedef (IDLE, HDR, XFER)
  - UART_W=8 constant
  - HDR_PREFIX constant
- One sub-module: uart_rr_pick, a combinational round-robin priority picker.
  - Inputs: req[N], ptr.
  - Outputs: onehot grant and binary index.
  - Reusable for a future RX demux.

Test Plan:
- Reset, then req=4'b0001 with 3 bytes 8'h11, 8'h22, 8'h33 (last on 8'h33), fifo_full=0:
  - grant=0001 after 1 cycle.
  - fifo_wr high for 3 consecutive cycles carrying 11, 22, 33.
  - IDLE and busy=0 on the next cycle.
- req=4'b1111 continuously, 1-byte packets:
  - Grant order 0, 1, 2, 3, 0, ...
  - Each packet takes 2 cycles.
- Requester 1 in mid-packet, then requester 2 asserts req:
  - Bytes of 1 are contiguous on fifo_data.
  - Requester 2 is granted only after 1's last byte is accepted.
- fifo_full=1 for 5 cycles during XFER:
  - fifo_wr=0 and ack=0 for those cycles.
  - The held byte 8'hA5 is written on the first non-full cycle, exactly once.
- rst pulsed during a 4-byte packet after 2 bytes:
  - Next cycle grant=0 and fifo_wr=0.
  - A subsequent req=4'b1010 grants requester 1 first.
- With UART_ARB_ID_HDR_EN, requester 2 sends 1 byte 8'h7E:
  - Written sequence is 8'hF2 then 8'h7E.
  - ack is asserted only with 8'h7E.
